// File: rtl/hls_xb_pkg.sv
// Shared types and default sizes for the HLS ap_fifo -> Xillybus read-stream bridge.
package hls_xb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int LEN_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    EOF    = 2'd3
  } state_t;

endpackage

// File: rtl/hls_rd_ring.sv
// Dual-pointer ring buffer with a registered read port; pointers carry a wrap bit
// so full and empty are distinguishable without a separate count register.
module hls_rd_ring
  import hls_xb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_same_idx;

  assign w_same_idx = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign empty      = (r_wr_ptr == r_rd_ptr);
  assign full       = w_same_idx && (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign fill       = r_wr_ptr - r_rd_ptr;
  assign rd_data    = r_rd_data;

  // Storage needs no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    end
  end

endmodule

// File: rtl/hls_to_xillybus_rd.sv
// Bridges an HLS ap_fifo write port into the Xillybus 32-bit read stream (non-FWFT),
// with optional end-of-frame after a word count latched when the host opens the file.
//
//   state  | meaning
//   IDLE   | file closed; no writes accepted, ring held flushed
//   STREAM | accepting HLS writes and host reads
//   DRAIN  | frame fully written; host still reading remaining words
//   EOF    | frame delivered; eof asserted until the host closes the file
module hls_to_xillybus_rd
  import hls_xb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                  bus_clk,
  input  logic                  ap_rst_n,
  input  logic [LEN_W-1:0]      frame_len,
  input  logic [DATA_W-1:0]     out_arr_din,
  input  logic                  out_arr_write,
  output logic                  out_arr_full_n,
  input  logic                  user_r_read_32_open,
  input  logic                  user_r_read_32_rden,
  output logic                  user_r_read_32_empty,
  output logic [DATA_W-1:0]     user_r_read_32_data,
  output logic                  user_r_read_32_eof,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  proto_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_len_q;
  logic [LEN_W-1:0]  r_words_in;
  logic [LEN_W-1:0]  r_words_out;
  logic [LEN_W-1:0]  w_words_in_nxt;
  logic [LEN_W-1:0]  w_words_out_nxt;
  logic              r_proto_err;
  logic              w_ring_empty;
  logic              w_ring_full;
  logic              w_acc_wr;
  logic              w_acc_rd;
  logic              w_flush;

  assign w_flush              = !user_r_read_32_open;
  assign out_arr_full_n       = (r_state == STREAM) && !w_ring_full;
  assign user_r_read_32_empty = w_ring_empty || (r_state == EOF);
  assign user_r_read_32_eof   = (r_state == EOF);
  assign proto_err            = r_proto_err;

  assign w_acc_wr = out_arr_write && out_arr_full_n;
  assign w_acc_rd = user_r_read_32_rden && !user_r_read_32_empty;

  assign w_words_in_nxt  = r_words_in  + {{(LEN_W-1){1'b0}}, w_acc_wr};
  assign w_words_out_nxt = r_words_out + {{(LEN_W-1){1'b0}}, w_acc_rd};

  hls_rd_ring #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ring (
    .clk     (bus_clk),
    .rst_n   (ap_rst_n),
    .flush   (w_flush),
    .wr_en   (w_acc_wr),
    .wr_data (out_arr_din),
    .rd_en   (w_acc_rd),
    .rd_data (user_r_read_32_data),
    .empty   (w_ring_empty),
    .full    (w_ring_full),
    .fill    (fill_level)
  );

  // IDLE is only entered with open low (or from reset), so open high in IDLE is the 0->1 edge.
  // Transitions use next-count values so full_n drops the cycle right after the last frame word.
  always_comb begin
    w_state_nxt = r_state;
    if (!user_r_read_32_open) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = STREAM;
        STREAM:  if ((r_len_q != '0) && w_acc_wr && (w_words_in_nxt == r_len_q))
                   w_state_nxt = DRAIN;
        DRAIN:   if (w_words_out_nxt == r_len_q)
                   w_state_nxt = EOF;
        EOF:     w_state_nxt = EOF;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= IDLE;
      r_len_q     <= '0;
      r_words_in  <= '0;
      r_words_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && user_r_read_32_open) begin
        r_len_q <= frame_len;
      end
      if (w_flush || (r_state == IDLE)) begin
        r_words_in  <= '0;
        r_words_out <= '0;
      end else begin
        r_words_in  <= w_words_in_nxt;
        r_words_out <= w_words_out_nxt;
      end
    end
  end

  always_ff @(posedge bus_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_proto_err <= 1'b0;
    end else if ((out_arr_write && !out_arr_full_n) ||
                 (user_r_read_32_rden && user_r_read_32_empty)) begin
      r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hls_to_xillybus_rd.sv
// Directed self-checking bench for hls_to_xillybus_rd: streaming, full/empty limits,
// framed EOF, pointer wrap, close-flush and asynchronous reset.
module tb_hls_to_xillybus_rd;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 4;
  localparam int LEN_W      = 16;

  logic                  bus_clk = 1'b0;
  logic                  ap_rst_n;
  logic [LEN_W-1:0]      frame_len;
  logic [DATA_W-1:0]     out_arr_din;
  logic                  out_arr_write;
  logic                  out_arr_full_n;
  logic                  user_r_read_32_open;
  logic                  user_r_read_32_rden;
  logic                  user_r_read_32_empty;
  logic [DATA_W-1:0]     user_r_read_32_data;
  logic                  user_r_read_32_eof;
  logic [DEPTH_LOG2:0]   fill_level;
  logic                  proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 bus_clk = ~bus_clk;

  hls_to_xillybus_rd #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LEN_W      (LEN_W)
  ) dut (
    .bus_clk              (bus_clk),
    .ap_rst_n             (ap_rst_n),
    .frame_len            (frame_len),
    .out_arr_din          (out_arr_din),
    .out_arr_write        (out_arr_write),
    .out_arr_full_n       (out_arr_full_n),
    .user_r_read_32_open  (user_r_read_32_open),
    .user_r_read_32_rden  (user_r_read_32_rden),
    .user_r_read_32_empty (user_r_read_32_empty),
    .user_r_read_32_data  (user_r_read_32_data),
    .user_r_read_32_eof   (user_r_read_32_eof),
    .fill_level           (fill_level),
    .proto_err            (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full_n"}, 32'(out_arr_full_n), 32'd0);
    check({tag, "_empty"},  32'(user_r_read_32_empty), 32'd1);
    check({tag, "_data"},   user_r_read_32_data, 32'd0);
    check({tag, "_eof"},    32'(user_r_read_32_eof), 32'd0);
    check({tag, "_fill"},   32'(fill_level), 32'd0);
    check({tag, "_perr"},   32'(proto_err), 32'd0);
  endtask

  initial begin
    ap_rst_n            = 1'b0;
    frame_len           = '0;
    out_arr_din         = '0;
    out_arr_write       = 1'b0;
    user_r_read_32_open = 1'b0;
    user_r_read_32_rden = 1'b0;
    #12;
    check_reset_outputs("rst");

    // Test 1: unbounded session, back-to-back writes with reads one cycle behind
    user_r_read_32_open = 1'b1;
    tick();
    ap_rst_n = 1'b1;
    tick();
    check("t1_full_n_stream", 32'(out_arr_full_n), 32'd1);
    check("t1_empty_start", 32'(user_r_read_32_empty), 32'd1);
    for (int c = 0; c < 6; c++) begin
      out_arr_write       = (c < 4);
      out_arr_din         = 32'h11 + 32'(c);
      user_r_read_32_rden = (c >= 1 && c < 5);
      tick();
      if (c >= 1 && c < 5) check("t1_data", user_r_read_32_data, 32'h11 + 32'(c - 1));
      if (c == 4) check("t1_empty_after_last", 32'(user_r_read_32_empty), 32'd1);
    end
    out_arr_write       = 1'b0;
    user_r_read_32_rden = 1'b0;
    check("t1_eof", 32'(user_r_read_32_eof), 32'd0);
    check("t1_perr", 32'(proto_err), 32'd0);

    // Test 2: overfill by one, then drain all sixteen
    for (int i = 1; i <= 17; i++) begin
      check("t2_full_n", 32'(out_arr_full_n), (i <= 16) ? 32'd1 : 32'd0);
      out_arr_write = 1'b1;
      out_arr_din   = 32'(i);
      tick();
    end
    out_arr_write = 1'b0;
    check("t2_fill16", 32'(fill_level), 32'd16);
    check("t2_perr", 32'(proto_err), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      user_r_read_32_rden = 1'b1;
      tick();
      check("t2_data", user_r_read_32_data, 32'(i));
    end
    user_r_read_32_rden = 1'b0;
    check("t2_empty", 32'(user_r_read_32_empty), 32'd1);
    check("t2_fill0", 32'(fill_level), 32'd0);

    // Test 3: three-word frame ending in EOF
    user_r_read_32_open = 1'b0;
    tick();
    check("t3_idle_full_n", 32'(out_arr_full_n), 32'd0);
    check("t3_idle_eof", 32'(user_r_read_32_eof), 32'd0);
    frame_len           = 16'd3;
    user_r_read_32_open = 1'b1;
    tick();
    check("t3_stream_full_n", 32'(out_arr_full_n), 32'd1);
    for (int k = 0; k < 3; k++) begin
      out_arr_write = 1'b1;
      out_arr_din   = 32'hA + 32'(k);
      tick();
    end
    out_arr_write = 1'b0;
    check("t3_drain_full_n", 32'(out_arr_full_n), 32'd0);
    check("t3_fill3", 32'(fill_level), 32'd3);
    check("t3_eof_early", 32'(user_r_read_32_eof), 32'd0);
    for (int k = 0; k < 3; k++) begin
      user_r_read_32_rden = 1'b1;
      tick();
      check("t3_data", user_r_read_32_data, 32'hA + 32'(k));
      if (k < 2) check("t3_eof_mid", 32'(user_r_read_32_eof), 32'd0);
    end
    user_r_read_32_rden = 1'b0;
    check("t3_eof", 32'(user_r_read_32_eof), 32'd1);
    check("t3_eof_empty", 32'(user_r_read_32_empty), 32'd1);
    tick();
    check("t3_eof_held", 32'(user_r_read_32_eof), 32'd1);
    user_r_read_32_open = 1'b0;
    tick();
    check("t3_close_eof", 32'(user_r_read_32_eof), 32'd0);
    check("t3_close_full_n", 32'(out_arr_full_n), 32'd0);

    // Test 4: eight words resident, concurrent write+read across pointer wrap
    frame_len           = 16'd0;
    user_r_read_32_open = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      out_arr_write = 1'b1;
      out_arr_din   = 32'h100 + 32'(k);
      tick();
    end
    check("t4_fill8", 32'(fill_level), 32'd8);
    for (int k = 0; k < 40; k++) begin
      out_arr_write       = 1'b1;
      out_arr_din         = 32'h108 + 32'(k);
      user_r_read_32_rden = 1'b1;
      tick();
      check("t4_data", user_r_read_32_data, 32'h100 + 32'(k));
      check("t4_fill", 32'(fill_level), 32'd8);
    end
    out_arr_write = 1'b0;

    // Test 5: close with five words buffered discards them
    for (int k = 0; k < 3; k++) begin
      user_r_read_32_rden = 1'b1;
      tick();
      check("t5_data", user_r_read_32_data, 32'h128 + 32'(k));
    end
    user_r_read_32_rden = 1'b0;
    check("t5_fill5", 32'(fill_level), 32'd5);
    user_r_read_32_open = 1'b0;
    tick();
    check("t5_flush_fill", 32'(fill_level), 32'd0);
    check("t5_flush_empty", 32'(user_r_read_32_empty), 32'd1);
    check("t5_perr_kept", 32'(proto_err), 32'd1);
    user_r_read_32_open = 1'b1;
    tick();
    out_arr_write = 1'b1;
    out_arr_din   = 32'h55;
    tick();
    out_arr_write       = 1'b0;
    user_r_read_32_rden = 1'b1;
    tick();
    user_r_read_32_rden = 1'b0;
    check("t5_reopen_data", user_r_read_32_data, 32'h55);

    // Test 6: asynchronous reset mid-stream
    for (int k = 0; k < 2; k++) begin
      out_arr_write = 1'b1;
      out_arr_din   = 32'h66 + 32'(k);
      tick();
    end
    out_arr_write = 1'b0;
    check("t6_fill2", 32'(fill_level), 32'd2);
    @(posedge bus_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hls_to_xillybus_rd.md
Name: hls_to_xillybus_rd

Overview:
- Output-side bridge from an HLS ap_fifo write port (out_arr_din / out_arr_write / out_arr_full_n) to the Xillybus 32-bit read stream (/dev/xillybus_read_32).
- Complements the input-side adapter that feeds the HLS core from the host-write FIFO.
- Buffers HLS results in a small ring, presents standard (non-FWFT) FIFO semantics to Xillybus, and optionally asserts EOF after a programmed frame length.

Parameters:
- DATA_W, 32, data word width.
- DEPTH_LOG2, 4, ring depth = 2**DEPTH_LOG2 words (16).
- LEN_W, 16, width of frame length and word counters.

Ports:
- bus_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- frame_len  in  LEN_W  words per open session; 0 = unbounded, no EOF.
- out_arr_din  in  DATA_W  HLS result word.
- out_arr_write  in  1  HLS write strobe.
- out_arr_full_n  out  1  ring can accept a word this cycle.
- user_r_read_32_open  in  1  host has the device file open.
- user_r_read_32_rden  in  1  Xillybus read request.
- user_r_read_32_empty  out  1  no word available.
- user_r_read_32_data  out  DATA_W  read data, valid the cycle after an accepted rden.
- user_r_read_32_eof  out  1  end of frame.
- fill_level  out  DEPTH_LOG2+1  words currently buffered.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (ap_rst_n=0, async): state IDLE; pointers and counters 0.
  - Outputs: out_arr_full_n=0, user_r_read_32_empty=1, user_r_read_32_data=0, user_r_read_32_eof=0, fill_level=0, proto_err=0.
- Ring: wr_ptr/rd_ptr are DEPTH_LOG2+1 bits (wrap bit).
  - empty = (wr_ptr==rd_ptr); full = equal index and differing wrap bit; fill_level = wr_ptr-rd_ptr (modulo).
- Write accept: out_arr_write && out_arr_full_n.
  - mem[wr_ptr] <= din; wr_ptr++; words_in++.
- Read accept: rden && !empty.
  - user_r_read_32_data <= mem[rd_ptr] (1-cycle latency); rd_ptr++; words_out++.
  - Data register holds its value otherwise.
- Simultaneous accepted read and write in one cycle: both pointers advance, fill_level unchanged.
- Written word visibility: a word written in cycle N is readable from cycle N+1 (empty deasserts at N+1). No same-cycle bypass.
- out_arr_full_n = (state==STREAM) && !full.
  - Registered-equivalent: derived from pointers and state, no combinational path from rden.
- State machine:
  - IDLE: full_n=0, eof=0.
    - open 0->1: sample frame_len into len_q; clear counters; go to STREAM.
  - STREAM: accepts writes and reads.
    - len_q!=0 and words_in reaches len_q: go to DRAIN.
  - DRAIN: full_n=0; reads continue.
    - words_out==len_q (ring then empty): go to EOF.
  - EOF: empty=1, eof=1, held until open deasserts.
  - Any state, open=0: go to IDLE next cycle.
    - Synchronous flush: pointers, counters, eof cleared. proto_err retained.
    - Buffered words are discarded.
- len_q==0: never leaves STREAM; counters wrap silently.
- Boundary conditions:
  - out_arr_write while full_n=0: word dropped, proto_err<=1.
  - rden while empty: ignored, data holds, proto_err<=1.
  - proto_err clears only on ap_rst_n.
- Reset asserted mid-transfer: immediate async return to the reset values above.

Decomposition:
- Package hls_xb_pkg:
  - state enum {IDLE, STREAM, DRAIN, EOF} (2-bit).
  - localparams for default DATA_W / DEPTH_LOG2 / LEN_W.
- Sub-module hls_rd_ring:
  - Dual-pointer ring with registered read port.
  - Outputs empty, full, fill.
- The top holds the FSM, counters and error flag.

Test Plan:
- Reset, then open=1, frame_len=0, write 0x11..0x14 back-to-back, rden once per cycle from cycle 2 -> data 0x11..0x14, each 1 cycle after its rden; empty high after the 4th read; eof=0.
- No reads, 17 write attempts -> full_n drops after the 16th, fill_level=16, 17th write dropped, proto_err=1; then 16 reads return words 1..16 in order.
- frame_len=3, write 0xA,0xB,0xC -> full_n=0 after the 3rd write; read all 3 -> eof=1 with empty=1 the cycle after the last read; open=0 -> eof=0 and state IDLE next cycle.
- Ring holds 8 words, simultaneous write+read every cycle for 40 cycles -> fill_level stays 8, pointer wrap is correct, data order preserved.
- Ring holds 5 words, open drops -> fill_level=0 and empty=1 next cycle; reopen, write 0x55 -> first read returns 0x55.
- ap_rst_n pulsed low mid-stream -> all outputs at reset values asynchronously; proto_err cleared.
